// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline definitions: freeze-FSM state encodings, forwarding select codes,
// and the packed stage write-enable bundle used by the hazard control unit.
package hazard_control_unit_pkg;

  typedef enum logic [1:0] {
    HZ_S_INIT    = 2'd0,
    HZ_S_RUN     = 2'd1,
    HZ_S_MEMWAIT = 2'd2,
    HZ_S_HALT    = 2'd3
  } hz_state_e;

  // Operand select codes consumed by the forwarding unit
  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } stage_we_t;

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter with enable; holds at all-ones once full.
// Latency: count visible the cycle after the enabling event. No backpressure.
module hazard_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline freeze FSM, load-use/branch hazard control and dmem timeout watchdog.
// Outputs are combinational from state and inputs; HAZARD_PERF_CNT_EN adds perf counters.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 5,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             memread_ex,
  input  logic             branch_taken_ex,
  input  logic             dmem_req_mem,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  hz_state_e        state_q, state_d;
  logic [TMO_W-1:0] wait_q, wait_d;
  logic             err_q, err_d;
  stage_we_t        we;
  logic             flush, bubble, run_rules;
  logic             load_use, mem_done;
  logic             stall_ev, flush_ev, wait_ev;

  assign load_use = memread_ex && (rd_ex != 5'd0) &&
                    ((use_rs1_id && (rs1_id == rd_ex)) || (use_rs2_id && (rs2_id == rd_ex)));
  // A ready strobe only counts against an access that is actually in flight
  assign mem_done = dmem_req_mem && dmem_ready;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    err_d     = err_q;
    we        = '0;
    flush     = 1'b0;
    bubble    = 1'b0;
    run_rules = 1'b0;
    stall_ev  = 1'b0;
    flush_ev  = 1'b0;
    wait_ev   = (state_q == HZ_S_MEMWAIT);
    unique case (state_q)
      HZ_S_INIT: begin
        flush   = 1'b1;
        bubble  = 1'b1;
        state_d = HZ_S_RUN;
      end
      HZ_S_RUN: run_rules = 1'b1;
      HZ_S_MEMWAIT: begin
        if (mem_done) begin
          run_rules = 1'b1;
          state_d   = HZ_S_RUN;
        end else if (wait_q == TMO_W'(MEM_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = HZ_S_HALT;
        end else begin
          wait_d = wait_q + TMO_W'(1);
        end
      end
      HZ_S_HALT: ;
      default: state_d = HZ_S_INIT;
    endcase

    // The freeze lifts in the same cycle ready arrives, so run rules apply there too
    if (run_rules) begin
      we = '1;
      if (dmem_req_mem && !dmem_ready) begin
        we      = '0;
        state_d = HZ_S_MEMWAIT;
        wait_d  = TMO_W'(1);
      end else if (branch_taken_ex) begin
        flush    = 1'b1;
        bubble   = 1'b1;
        flush_ev = 1'b1;
      end else if (load_use) begin
        we.pc    = 1'b0;
        we.ifid  = 1'b0;
        bubble   = 1'b1;
        stall_ev = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HZ_S_INIT;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign pc_write        = we.pc;
  assign ifid_write      = we.ifid;
  assign idex_write      = we.idex;
  assign exmem_write     = we.exmem;
  assign memwb_write     = we.memwb;
  assign ifid_flush      = flush;
  assign idex_bubble     = bubble;
  assign mem_timeout_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .en(stall_ev), .cnt(stall_cnt));
  hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .reset(reset), .en(flush_ev), .cnt(flush_cnt));
  hazard_perf_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk(clk), .reset(reset), .en(wait_ev), .cnt(wait_cnt));
`else
  logic unused_perf_ev;
  assign unused_perf_ev = ^{stall_ev, flush_ev, wait_ev};
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboarded random/directed bench for hazard_control_unit with MEM_TIMEOUT=4.
module tb_hazard_control_unit;

  localparam int TMO   = 4;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [4:0]       rs1_id = '0, rs2_id = '0, rd_ex = '0;
  logic             use_rs1_id = 0, use_rs2_id = 0, memread_ex = 0, branch_taken_ex = 0;
  logic             dmem_req_mem = 0, dmem_ready = 0;
  logic             pc_write, ifid_write, idex_write, exmem_write, memwb_write;
  logic             ifid_flush, idex_bubble, mem_timeout_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;

  always #5 clk = ~clk;

  hazard_control_unit #(.MEM_TIMEOUT(TMO), .TMO_W(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .rd_ex(rd_ex), .memread_ex(memread_ex), .branch_taken_ex(branch_taken_ex),
    .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .memwb_write(memwb_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .mem_timeout_err(mem_timeout_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt));

  typedef struct packed {
    logic pc, ifid, idex, exmem, memwb, flush, bubble, err;
    logic [CNT_W-1:0] stall, flushc, waitc;
  } exp_t;

  exp_t  sb[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: pipeline situation described by plain flags and a wait-cycle count
  bit               m_init = 1, m_halt = 0, m_err = 0;
  int               m_waited = 0;
  logic [CNT_W-1:0] m_stall = '0, m_flush = '0, m_wait = '0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  task automatic step(input string tag, input bit rst_i,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                      input bit u1, input bit u2, input bit mr, input bit br,
                      input bit rq, input bit rdy);
    exp_t e;
    bit   lu, run;
    @(posedge clk);
    #1;
    reset = rst_i; rs1_id = r1; rs2_id = r2; rd_ex = rd;
    use_rs1_id = u1; use_rs2_id = u2; memread_ex = mr; branch_taken_ex = br;
    dmem_req_mem = rq; dmem_ready = rdy;
    if (rst_i) begin
      m_init = 1; m_halt = 0; m_err = 0; m_waited = 0;
      m_stall = '0; m_flush = '0; m_wait = '0;
    end
    e = '0;
    e.err = m_err;
`ifdef HAZARD_PERF_CNT_EN
    e.stall = m_stall; e.flushc = m_flush; e.waitc = m_wait;
`endif
    lu  = mr && (rd != 0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
    run = 0;
    if (rst_i) begin
      e.flush = 1; e.bubble = 1;
    end else if (m_init) begin
      e.flush = 1; e.bubble = 1; m_init = 0;
    end else if (m_halt) begin
      run = 0;
    end else if (m_waited > 0) begin
      m_wait = sat_inc(m_wait);
      if (rq && rdy) begin
        m_waited = 0; run = 1;
      end else if (m_waited == TMO) begin
        m_err = 1; m_halt = 1; m_waited = 0;
      end else begin
        m_waited++;
      end
    end else begin
      run = 1;
    end
    if (run) begin
      if (rq && !rdy) begin
        m_waited = 1;
      end else begin
        {e.pc, e.ifid, e.idex, e.exmem, e.memwb} = 5'b11111;
        if (br) begin
          e.flush = 1; e.bubble = 1; m_flush = sat_inc(m_flush);
        end else if (lu) begin
          e.pc = 0; e.ifid = 0; e.bubble = 1; m_stall = sat_inc(m_stall);
        end
      end
    end
    sb.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle presents a response; compare mid-cycle
  initial begin
    exp_t  exp_v, act;
    string t;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_v = sb.pop_front();
        t     = tag_q.pop_front();
        act   = {pc_write, ifid_write, idex_write, exmem_write, memwb_write,
                 ifid_flush, idex_bubble, mem_timeout_err, stall_cnt, flush_cnt, wait_cnt};
        checks++;
        if (act !== exp_v) begin
          errors++;
          $display("FAIL %s: got %h expected %h", t, act, exp_v);
        end
      end
    end
  end

  initial begin
    step("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle("init");
    idle("run");
    step("lu_rs1", 0, 5, 0, 5, 1, 0, 1, 0, 0, 0);
    step("lu_after", 0, 5, 0, 0, 1, 0, 0, 0, 0, 0);
    step("lu_rd0", 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    step("lu_rs2", 0, 1, 9, 9, 1, 1, 1, 0, 0, 0);
    step("br_lu", 0, 0, 7, 7, 0, 1, 1, 1, 0, 0);
    step("rdy_noreq", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("mw1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("mw2_br", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step("mw3_br", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step("mw_done_br", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle("mw_after");
    for (int i = 0; i < 6; i++) step("tmo", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("halt_late_rdy", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle("halt");
    step("tmo_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle("reinit");
    idle("rerun");
    for (int i = 0; i < 3000; i++) begin
      step("rand", ($urandom_range(0, 99) < 2),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
           $urandom_range(0, 1) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) != 0, $urandom_range(0, 9) != 0);
    end
    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
